// File: rtl/alu_issue_sequencer_pkg.sv
// Shared constants for the ALU issue sequencer.
// Command ops, ALU opcodes and FSM state encoding.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4;
  localparam logic [2:0] OP_BNE = 3'd5;
  localparam logic [2:0] OP_BLT = 3'd6;
  localparam logic [2:0] OP_BGT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Command/response handshake bundle of the ALU issue sequencer.
// slave = sequencer side, master = decode/writeback side.
interface alu_issue_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_write_en;
  logic             resp_branch_taken;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a,
    input  cmd_b, cmd_tag, resp_ready,
    output cmd_ready, resp_valid,
    output resp_result, resp_tag,
    output resp_write_en,
    output resp_branch_taken
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a,
    output cmd_b, cmd_tag, resp_ready,
    input  cmd_ready, resp_valid,
    input  resp_result, resp_tag,
    input  resp_write_en,
    input  resp_branch_taken
  );
endinterface

// File: rtl/alu_issue_sequencer_decoder.sv
// Maps a command op to its ALU opcode and branch flag.
// Branches compare by subtraction and read the ALU flags.
module alu_cmd_decoder
  import alu_issue_pkg::*;
(
  input  logic [2:0] i_op,
  output logic [3:0] o_alu_opcode,
  output logic       o_is_branch
);

  always_comb begin
    o_alu_opcode = ALU_SUB;
    o_is_branch  = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADD): o_alu_opcode = ALU_ADD;
      (i_op == OP_SUB): o_alu_opcode = ALU_SUB;
      (i_op == OP_AND): o_alu_opcode = ALU_AND;
      (i_op == OP_OR):  o_alu_opcode = ALU_OR;
      default: begin
        o_alu_opcode = ALU_SUB;
        o_is_branch  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issues one command at a time to an external ALU,
// resolves branches from its flags and returns a response.
module alu_issue_sequencer
  import alu_issue_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_sequencer_if.slave bus,
  output logic [31:0]      alu_data_in1,
  output logic [31:0]      alu_data_in2,
  output logic [3:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_gt,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] branches_taken
);

  state_e           r_state;
  state_e           w_next;
  logic [31:0]      r_in1;
  logic [31:0]      r_in2;
  logic [3:0]       r_opc;
  logic [2:0]       r_op;
  logic             r_is_br;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_result;
  logic             r_wen;
  logic             r_taken;
  logic [CNT_W-1:0] r_ops;
  logic [CNT_W-1:0] r_brs;

  logic [3:0] w_dec_opc;
  logic       w_dec_br;
  logic       w_cmd_ready;
  logic       w_resp_valid;
  logic       w_accept;
  logic       w_hs;
  logic       w_taken;

  alu_cmd_decoder u_dec (
    .i_op         (bus.cmd_op),
    .o_alu_opcode (w_dec_opc),
    .o_is_branch  (w_dec_br)
  );

  always_comb begin
    w_next       = r_state;
    w_cmd_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_accept     = 1'b0;
    w_hs         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_hs   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    unique case (1'b1)
      (r_op == OP_BEQ): w_taken = alu_zero;
      (r_op == OP_BNE): w_taken = !alu_zero;
      (r_op == OP_BLT): w_taken = alu_lt;
      (r_op == OP_BGT): w_taken = alu_gt;
      default:          w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_in1    <= '0;
      r_in2    <= '0;
      r_opc    <= '0;
      r_op     <= '0;
      r_is_br  <= 1'b0;
      r_tag    <= '0;
      r_result <= '0;
      r_wen    <= 1'b0;
      r_taken  <= 1'b0;
      r_ops    <= '0;
      r_brs    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_in1   <= bus.cmd_a;
        r_in2   <= bus.cmd_b;
        r_opc   <= w_dec_opc;
        r_op    <= bus.cmd_op;
        r_is_br <= w_dec_br;
        r_tag   <= bus.cmd_tag;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_taken  <= w_taken;
        r_wen    <= !r_is_br;
      end
      // counters wrap freely
      if (w_hs) begin
        r_ops <= r_ops + CNT_W'(1);
        r_brs <= r_brs + CNT_W'(r_taken);
      end
    end
  end

  assign bus.cmd_ready         = w_cmd_ready;
  assign bus.resp_valid        = w_resp_valid;
  assign bus.resp_result       = r_result;
  assign bus.resp_tag          = r_tag;
  assign bus.resp_write_en     = r_wen;
  assign bus.resp_branch_taken = r_taken;
  assign alu_data_in1          = r_in1;
  assign alu_data_in2          = r_in2;
  assign alu_opcode            = r_opc;
  assign ops_done              = r_ops;
  assign branches_taken        = r_brs;

endmodule
